// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: prefix codes,
// frame FSM state encoding and default timing parameters.
package ps2_pkg;

    // Scan-code prefixes handled by the byte layer
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // Defaults: 2-flop synchronizer, 1 ms frame timeout at 50 MHz
    localparam int PS2_SYNC_STAGES_DEFAULT    = 2;
    localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 50000;

    // Frame FSM states, one per field of the device-to-host frame
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes the raw PS/2 pins,
// detects falling edges of the PS/2 clock, walks the start/data/parity/stop
// fields and discards partial frames after a period of bus inactivity.
//
// rx_done / rx_err are single-cycle strobes asserted combinationally in the
// cycle the stop-bit edge is detected, so the parent can register its outputs
// one cycle later. rx_byte is held stable from the last data bit until the
// next start bit, so it is valid whenever rx_done is high. There is no
// back-pressure: a consumer must act on the strobe in the cycle it is high.
import ps2_pkg::*;

module ps2_frame_rx #(
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES_DEFAULT,   // minimum 2
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk_raw,
    input  logic       ps2_dat_raw,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_err,
    output ps2_state_e rx_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   bit_in;
    logic                   fall;

    ps2_state_e             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic                   parity_bit;
    logic [CNT_W-1:0]       to_cnt;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign bit_in = dat_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    assign rx_byte  = shift_reg;
    assign rx_state = state;

    // Synchronizer chains; idle PS/2 lines are high, so reset to 1 avoids a false edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_raw};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_raw};
            clk_prev <= clk_s;
        end
    end

    // Frame FSM with inactivity timeout; a falling edge always wins over the timeout
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            to_cnt     <= '0;
        end else if (fall) begin
            to_cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_reg <= {bit_in, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_bit <= bit_in;
                    state      <= ST_STOP;
                end
                ST_STOP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end else if (state != ST_IDLE) begin
            if (to_cnt == CNT_LAST) begin
                state  <= ST_IDLE;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // Stop-bit verdict: parity and stop bit are judged on the stop-bit edge itself
    always_comb begin
        rx_done = 1'b0;
        rx_err  = 1'b0;
        if (fall && (state == ST_STOP)) begin
            if (odd_parity_ok(shift_reg, parity_bit) && bit_in) begin
                rx_done = 1'b1;
            end else begin
                rx_err = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard front end: frame reception plus make/break/extended prefix
// decoding. last_key_received holds the most recent make code for the game FSM.
// Optional build macro PS2_BREAK_CLEAR_EN: a break of the currently held key
// clears last_key_received/key_extended so the game sees "no key held".
// dbg_frame_state exposes the frame FSM state (ps2_pkg::ps2_state_e encoding).
import ps2_pkg::*;

module ps2_key_receiver #(
    parameter int SYNC_STAGES    = PS2_SYNC_STAGES_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] last_key_received,
    output logic       key_extended,
    output logic       key_valid,
    output logic       key_break,
    output logic [7:0] break_code,
    output logic       frame_error,
    output logic [1:0] dbg_frame_state
);

    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;
    ps2_state_e rx_state;

    logic       ext_flag;
    logic       brk_flag;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk_raw (PS2_CLK),
        .ps2_dat_raw (PS2_DAT),
        .rx_byte     (rx_byte),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .rx_state    (rx_state)
    );

    assign dbg_frame_state = rx_state;

    // Byte layer: prefix tracking and registered key outputs; pulses default low each cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_key_received <= 8'h00;
            key_extended      <= 1'b0;
            key_valid         <= 1'b0;
            key_break         <= 1'b0;
            break_code        <= 8'h00;
            frame_error       <= 1'b0;
            ext_flag          <= 1'b0;
            brk_flag          <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_break   <= 1'b0;
            frame_error <= 1'b0;
            if (rx_err) begin
                // A corrupted byte may have been part of a prefix sequence
                frame_error <= 1'b1;
                ext_flag    <= 1'b0;
                brk_flag    <= 1'b0;
            end else if (rx_done) begin
                if (rx_byte == PS2_PREFIX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_PREFIX_BREAK) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    break_code <= rx_byte;
                    key_break  <= 1'b1;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
`ifdef PS2_BREAK_CLEAR_EN
                    if ((rx_byte == last_key_received) && (ext_flag == key_extended)) begin
                        last_key_received <= 8'h00;
                        key_extended      <= 1'b0;
                    end
`else
                    // Break sequences leave the held make code untouched
`endif
                end else begin
                    last_key_received <= rx_byte;
                    key_extended      <= ext_flag;
                    key_valid         <= 1'b1;
                    ext_flag          <= 1'b0;
                    brk_flag          <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: directed scenarios followed by random frames,
// checked against a scan-code level model of the keyboard protocol.
module tb_ps2_key_receiver;

    localparam int TB_TIMEOUT = 200;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] last_key_received;
    logic       key_extended;
    logic       key_valid;
    logic       key_break;
    logic [7:0] break_code;
    logic       frame_error;
    logic [1:0] dbg_frame_state;

    int tests_run = 0;
    int tests_failed = 0;

    // Observed pulse counts (counted per high cycle, so a stretched pulse shows up)
    int seen_valid = 0;
    int seen_break = 0;
    int seen_err = 0;

    // Model state
    logic [7:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_kext = 1'b0;
    logic [7:0] m_bcode = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         m_valid = 0;
    int         m_break = 0;
    int         m_err = 0;

    ps2_key_receiver #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .PS2_CLK           (PS2_CLK),
        .PS2_DAT           (PS2_DAT),
        .last_key_received (last_key_received),
        .key_extended      (key_extended),
        .key_valid         (key_valid),
        .key_break         (key_break),
        .break_code        (break_code),
        .frame_error       (frame_error),
        .dbg_frame_state   (dbg_frame_state)
    );

    // Clock
    always #10 clock = ~clock;

    // Checks
    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every key_valid must deliver the next expected make code
    always @(negedge clock) begin
        if (resetn) begin
            if (key_valid) begin
                seen_valid++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $error("FAIL sb_unexpected_valid observed=%h expected=none", last_key_received);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    assert (last_key_received === e) else begin
                        tests_failed++;
                        $error("FAIL sb_key observed=%h expected=%h", last_key_received, e);
                    end
                end
            end
            if (key_break) seen_break++;
            if (frame_error) seen_err++;
        end
    end

    // Protocol model for one accepted byte
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_bcode = b;
            m_break++;
`ifdef PS2_BREAK_CLEAR_EN
            if (b == m_last && m_ext == m_kext) begin
                m_last = 8'h00;
                m_kext = 1'b0;
            end
`endif
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_last = b;
            m_kext = m_ext;
            m_valid++;
            exp_q.push_back(b);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Driver: one PS/2 bit, data set up before the falling clock edge
    task automatic send_bit(input logic v);
        PS2_DAT = v;
        repeat (5) @(posedge clock);
        PS2_CLK = 1'b0;
        repeat (15) @(posedge clock);
        PS2_CLK = 1'b1;
        repeat (15) @(posedge clock);
    endtask

    // Driver: full frame; model is updated first so the scoreboard is primed
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (^b) ? 1'b0 : 1'b1;
        if (bad_par) par = ~par;
        if (bad_par || bad_stop) begin
            m_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            model_byte(b);
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(bad_stop ? 1'b0 : 1'b1);
        PS2_DAT = 1'b1;
        repeat (5) @(posedge clock);
    endtask

    task automatic check_all(input string tag);
        @(negedge clock);
        chk({tag, ".last"},  int'(last_key_received), int'(m_last));
        chk({tag, ".ext"},   int'(key_extended),      int'(m_kext));
        chk({tag, ".bcode"}, int'(break_code),        int'(m_bcode));
        chk({tag, ".nvalid"}, seen_valid, m_valid);
        chk({tag, ".nbreak"}, seen_break, m_break);
        chk({tag, ".nerr"},   seen_err,   m_err);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, ".last"},  int'(last_key_received), 0);
        chk({tag, ".ext"},   int'(key_extended),      0);
        chk({tag, ".valid"}, int'(key_valid),         0);
        chk({tag, ".brk"},   int'(key_break),         0);
        chk({tag, ".bcode"}, int'(break_code),        0);
        chk({tag, ".ferr"},  int'(frame_error),       0);
    endtask

    initial begin
        int kind;
        logic [7:0] b;

        // Reset
        resetn = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("reset");
        chk("reset.state", int'(dbg_frame_state), 0);
        resetn = 1'b1;
        repeat (4) @(posedge clock);

        // Plain make code
        send_frame(8'h1D, 1'b0, 1'b0);
        check_all("make_1d");

        // Break of the held key
        send_frame(8'hF0, 1'b0, 1'b0);
        check_all("break_prefix");
        send_frame(8'h1D, 1'b0, 1'b0);
        check_all("break_1d");

        // Extended make and break
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_all("ext_make_75");
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check_all("ext_break_75");

        // Parity error clears a pending prefix
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b1, 1'b0);
        check_all("parity_err");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("after_err_1c");

        // Stop-bit error
        send_frame(8'h2B, 1'b0, 1'b1);
        check_all("stop_err");

        // Partial frame abandoned by timeout
        send_frame(8'h75, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        PS2_DAT = 1'b1;
        repeat (TB_TIMEOUT + 10) @(posedge clock);
        check_all("timeout_quiet");
        chk("timeout.state", int'(dbg_frame_state), 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("after_timeout_1c");

        // Typematic repeat
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("repeat_1c");

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #3 resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("midreset");
        m_last = 8'h00; m_kext = 1'b0; m_bcode = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        exp_q.delete();
        resetn = 1'b1;
        repeat (4) @(posedge clock);
        send_frame(8'h75, 1'b0, 1'b0);
        check_all("after_reset_75");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            b = 8'($urandom_range(1, 8'hDF));
            case (kind)
                0: send_frame(8'hE0, 1'b0, 1'b0);
                1: send_frame(8'hF0, 1'b0, 1'b0);
                2: send_frame(b, 1'b1, 1'b0);
                3: send_frame(b, 1'b0, 1'b1);
                4: send_frame((m_last != 8'h00) ? m_last : 8'h1C, 1'b0, 1'b0);
                default: send_frame(b, 1'b0, 1'b0);
            endcase
            check_all("random");
        end

        repeat (10) @(posedge clock);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
